// File: rtl/scan_sel_mux.sv
// Registered N-channel select mux with an auto-scan / manual-select sequencer.
// Define SCAN_MASK_EN to add ch_mask, restricting which channels the scan visits.
module scan_sel_mux #(
    parameter int unsigned   NCH         = 4,
    parameter int unsigned   W           = 1,
    parameter int unsigned   DWELL       = 1,
    parameter logic [W-1:0]  DEFAULT_VAL = '0,
    localparam int unsigned  SELW        = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   man_sel,
    input  logic [NCH*W-1:0]  din,
`ifdef SCAN_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   cur_sel,
    output logic              valid,
    output logic              wrap,
    output logic              err
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, MAN} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wrap_pend_q, wrap_pend_d;
    logic [W-1:0]    dout_d;
    logic [SELW-1:0] cur_sel_d;
    logic            valid_d, wrap_d, err_d;

    logic [NCH-1:0]  mask;
    logic [W-1:0]    sel_data;
    logic [SELW-1:0] first_idx, next_idx;
    logic            found, legal, present_ok;

`ifdef SCAN_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    // Channel mux; any index outside 0..NCH-1 falls through to DEFAULT_VAL.
    always_comb begin : sel_mux
        sel_data = DEFAULT_VAL;
        for (int k = 0; k < NCH; k++) begin
            if (sel_q == SELW'(k)) sel_data = din[k*W +: W];
        end
    end

    // Scan order: lowest enabled index above the current one, else lowest enabled.
    always_comb begin : scan_order
        first_idx = '0;
        next_idx  = '0;
        found     = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) first_idx = SELW'(k);
        end
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (SELW'(k) > sel_q)) begin
                next_idx = SELW'(k);
                found    = 1'b1;
            end
        end
        if (!found) next_idx = first_idx;
    end

    assign legal      = (sel_q <= SELW'(NCH - 1));
    assign present_ok = legal && !((state_q == SCAN) && (mask == '0));

    // Next-state, sequencer and registered-output logic.
    always_comb begin : next_logic
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        wrap_pend_d = wrap_pend_q;
        dout_d      = dout;
        cur_sel_d   = cur_sel;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        err_d       = err;
        if (en) begin
            if (state_q == IDLE) begin
                state_d     = mode ? MAN : SCAN;
                sel_d       = mode ? man_sel : first_idx;
                cnt_d       = '0;
                wrap_pend_d = 1'b0;
            end else begin
                dout_d    = present_ok ? sel_data : DEFAULT_VAL;
                cur_sel_d = sel_q;
                valid_d   = present_ok;
                wrap_d    = wrap_pend_q;
                err_d     = !legal;
                wrap_pend_d = 1'b0;
                if (mode) begin
                    state_d = MAN;
                    sel_d   = man_sel;
                    cnt_d   = '0;
                end else if (state_q == MAN) begin
                    state_d = SCAN;
                    sel_d   = first_idx;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d = '0;
                    if (mask != '0) begin
                        sel_d       = next_idx;
                        wrap_pend_d = (next_idx <= sel_q);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            wrap_pend_q <= 1'b0;
            dout        <= '0;
            cur_sel     <= '0;
            valid       <= 1'b0;
            wrap        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            wrap_pend_q <= wrap_pend_d;
            dout        <= dout_d;
            cur_sel     <= cur_sel_d;
            valid       <= valid_d;
            wrap        <= wrap_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_scan_sel_mux.sv
// Directed bench for scan_sel_mux: a 4x1 DWELL=1 instance and a 3x8 DWELL=2 instance.
module tb_scan_sel_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       en_a, mode_a, dout_a, valid_a, wrap_a, err_a;
    logic [1:0] man_sel_a, cur_sel_a;
    logic [3:0] din_a, mask_a;

    logic       en_b, mode_b, valid_b, wrap_b, err_b;
    logic [1:0] man_sel_b, cur_sel_b;
    logic [23:0] din_b;
    logic [7:0] dout_b;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sel_mux #(.NCH(4), .W(1), .DWELL(1), .DEFAULT_VAL(1'b1)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .mode(mode_a), .man_sel(man_sel_a),
        .din(din_a),
`ifdef SCAN_MASK_EN
        .ch_mask(mask_a),
`endif
        .dout(dout_a), .cur_sel(cur_sel_a), .valid(valid_a), .wrap(wrap_a), .err(err_a)
    );

    scan_sel_mux #(.NCH(3), .W(8), .DWELL(2), .DEFAULT_VAL(8'hA5)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .mode(mode_b), .man_sel(man_sel_b),
        .din(din_b),
`ifdef SCAN_MASK_EN
        .ch_mask(3'b111),
`endif
        .dout(dout_b), .cur_sel(cur_sel_b), .valid(valid_b), .wrap(wrap_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pat [8] = '{4'b0110, 4'b1001, 4'b1111, 4'b0000,
                            4'b0101, 4'b1010, 4'b0011, 4'b1100};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        logic       found;
        int         bsel;

        reset = 1'b1;
        en_a = 1'b1; mode_a = 1'b0; man_sel_a = 2'd0; din_a = 4'b0110; mask_a = 4'hF;
        en_b = 1'b1; mode_b = 1'b0; man_sel_b = 2'd0; din_b = {8'h33, 8'h22, 8'h11};
        #12;
        check("rst_dout_a",  32'(dout_a),    32'd0);
        check("rst_sel_a",   32'(cur_sel_a), 32'd0);
        check("rst_valid_a", 32'(valid_a),   32'd0);
        check("rst_wrap_a",  32'(wrap_a),    32'd0);
        check("rst_err_a",   32'(err_a),     32'd0);
        check("rst_dout_b",  32'(dout_b),    32'd0);
        reset = 1'b0;

        // First enabled edge only leaves IDLE.
        step();
        check("idle_valid_a", 32'(valid_a), 32'd0);
        check("idle_valid_b", 32'(valid_b), 32'd0);

        // Free-running scan on both instances, A with live-changing input.
        for (int i = 0; i < 8; i++) begin
            din_a = pat[i];
            step();
            p = pat[i];
            bsel = (i / 2) % 3;
            check("scan_sel_a",   32'(cur_sel_a), 32'(i % 4));
            check("scan_wrap_a",  32'(wrap_a),    32'((i > 0) && (i % 4 == 0)));
            check("scan_dout_a",  32'(dout_a),    32'(p[i % 4]));
            check("scan_valid_a", 32'(valid_a),   32'd1);
            check("scan_sel_b",   32'(cur_sel_b), 32'(bsel));
            check("scan_wrap_b",  32'(wrap_b),    32'(i == 6));
            check("scan_dout_b",  32'(dout_b),    32'(8'h11 * (bsel + 1)));
            check("scan_err_b",   32'(err_b),     32'd0);
        end

        // Manual select out of range, then back to a legal channel.
        mode_b = 1'b1; man_sel_b = 2'd3;
        step(); step();
        check("man_bad_dout",  32'(dout_b),  32'hA5);
        check("man_bad_valid", 32'(valid_b), 32'd0);
        check("man_bad_err",   32'(err_b),   32'd1);
        step();
        check("man_err_sticky", 32'(err_b), 32'd1);
        man_sel_b = 2'd1;
        step(); step();
        check("man_ok_err",   32'(err_b),   32'd0);
        check("man_ok_valid", 32'(valid_b), 32'd1);
        check("man_ok_dout",  32'(dout_b),  32'h22);

        // Manual back to scan restarts at index 0 without a wrap.
        mode_b = 1'b0;
        step(); step();
        check("restart_sel",  32'(cur_sel_b), 32'd0);
        check("restart_wrap", 32'(wrap_b),    32'd0);
        check("restart_dout", 32'(dout_b),    32'h11);

        // Drop en mid-dwell: outputs freeze, valid drops; remaining dwell then completes.
        en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_sel",   32'(cur_sel_b), 32'd0);
            check("hold_dout",  32'(dout_b),    32'h11);
            check("hold_valid", 32'(valid_b),   32'd0);
            check("hold_wrap",  32'(wrap_b),    32'd0);
        end
        en_b = 1'b1;
        step();
        check("resume_sel",   32'(cur_sel_b), 32'd0);
        check("resume_valid", 32'(valid_b),   32'd1);
        step();
        check("resume_adv", 32'(cur_sel_b), 32'd1);

        // Async reset while A presents channel 2.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (cur_sel_a == 2'd2) found = 1'b1;
            else step();
        end
        check("reach_sel2", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("async_sel_a",   32'(cur_sel_a), 32'd0);
        check("async_dout_a",  32'(dout_a),    32'd0);
        check("async_valid_a", 32'(valid_a),   32'd0);
        check("async_dout_b",  32'(dout_b),    32'd0);
        step();
        reset = 1'b0;
        step(); step();
        check("post_rst_sel_a",   32'(cur_sel_a), 32'd0);
        check("post_rst_valid_a", 32'(valid_a),   32'd1);
        check("post_rst_wrap_a",  32'(wrap_a),    32'd0);
        check("post_rst_sel_b",   32'(cur_sel_b), 32'd0);

`ifdef SCAN_MASK_EN
        // Masked scan visits only channels 1 and 3.
        mask_a = 4'b1010;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            check("mask_sel",  32'(cur_sel_a), 32'((i % 2 == 1) ? 3 : 1));
            check("mask_wrap", 32'(wrap_a),    32'((i > 0) && (i % 2 == 0)));
        end
        mask_a = 4'b0000;
        step();
        check("mask0_valid", 32'(valid_a), 32'd0);
        check("mask0_dout",  32'(dout_a),  32'd1);
        step();
        check("mask0_hold", 32'(cur_sel_a), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
